// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-port (fetch/load) arbiter and byte sequencer for the boot ROM
module rom_port_arbiter #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [7:0]               rom_data,
    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    output logic                     i_gnt,
    output logic                     i_valid,
    output logic [31:0]              i_data,
    input  logic                     d_req,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [1:0]               d_size,
    output logic                     d_gnt,
    output logic                     d_valid,
    output logic [31:0]              d_data
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [1:0]               cnt;
    logic [1:0]               last_idx;
    logic                     owner_d;
    logic                     last_d;
    logic [31:0]              asm_word;
    logic [31:0]              asm_next;
    logic [31:0]              i_word;
    logic [31:0]              d_word;
    logic                     grant_i;
    logic                     grant_d;
    logic [1:0]               d_last_idx;

    // Index of the final byte lane: byte=0, half=1, word (2 or 3)=3.
    always_comb begin
        d_last_idx = 2'd3;
        case (d_size)
            2'd0:    d_last_idx = 2'd0;
            2'd1:    d_last_idx = 2'd1;
            default: d_last_idx = 2'd3;
        endcase
    end

    // On a tie, the port that did not own the previous grant wins.
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (i_req && (!d_req || last_d)) begin
                        grant_i = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_i || grant_d) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (cnt == last_idx) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        asm_next                   = asm_word;
        asm_next[{cnt, 3'b000} +: 8] = rom_data;
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_valid  = (state == DONE) && !owner_d;
    assign d_valid  = (state == DONE) && owner_d;
    assign i_data   = i_word;
    assign d_data   = d_word;
    assign rom_addr = (state == READ) ? base + ADDRESS_WIDTH'(cnt) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            cnt      <= 2'd0;
            last_idx <= 2'd0;
            owner_d  <= 1'b0;
            last_d   <= 1'b1;
            asm_word <= 32'd0;
            i_word   <= 32'd0;
            d_word   <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        base     <= grant_i ? i_addr : d_addr;
                        last_idx <= grant_i ? 2'd3 : d_last_idx;
                        owner_d  <= grant_d;
                        last_d   <= grant_d;
                        cnt      <= 2'd0;
                        asm_word <= 32'd0;
                    end
                end
                READ: begin
                    asm_word <= asm_next;
                    cnt      <= cnt + 2'd1;
                    // Result registers are loaded with the final byte so they hold until the next completion.
                    if (cnt == last_idx) begin
                        if (owner_d) begin
                            d_word <= asm_next;
                        end else begin
                            i_word <= asm_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed vector bench for rom_port_arbiter
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_data;
    logic        d_req;
    logic [7:0]  d_addr;
    logic [1:0]  d_size;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_data;

    logic [7:0] rom [256];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        is_d;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic [31:0] exp;
        int          n;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    rom_port_arbiter #(.ADDRESS_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_size   (d_size),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_data   (d_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One transaction starting in an IDLE cycle (cycle 0), tracked until valid or timeout.
    task automatic run_txn(input logic is_d, input logic [7:0] addr, input logic [1:0] size,
                           input logic [31:0] exp, input int n, input string name);
        int   vcyc;
        logic addr_ok;
        logic other_valid;
        vcyc        = -1;
        addr_ok     = 1'b1;
        other_valid = 1'b0;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_addr = addr; d_size = size;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk);
        check({name, "_gnt"}, {30'd0, i_gnt, d_gnt}, is_d ? 32'd1 : 32'd2);
        for (int cyc = 1; cyc <= 20 && vcyc < 0; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc <= n && rom_addr !== 8'(addr + cyc - 1)) addr_ok = 1'b0;
            if (is_d ? d_valid : i_valid) vcyc = cyc;
            if (is_d ? i_valid : d_valid) other_valid = 1'b1;
        end
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        check({name, "_lat"}, vcyc, n + 1);
        check({name, "_data"}, is_d ? d_data : i_data, exp);
        check({name, "_addrseq"}, {31'd0, addr_ok}, 32'd1);
        check({name, "_other"}, {31'd0, other_valid}, 32'd0);
    endtask

    initial begin
        int          gcyc [$];
        logic        gown [$];
        int          exp_c [4];
        logic        exp_o [4];
        int          i_done;
        int          d_done;
        int          act_c;
        logic        act_o;
        logic        seen_v;

        for (int a = 0; a < 256; a++) rom[a] = 8'(a) ^ 8'hA5;
        rom[0]   = 8'hB7; rom[1]   = 8'h07; rom[2]   = 8'h00; rom[3]   = 8'h00;
        rom[36]  = 8'h48; rom[37]  = 8'h65; rom[38]  = 8'h6C;
        rom[120] = 8'h48; rom[121] = 8'h65; rom[122] = 8'h6C; rom[123] = 8'h6C;
        rom[254] = 8'h01; rom[255] = 8'h01;

        vecs[0] = '{1'b0, 8'd0,   2'd0, 32'h000007B7, 4};
        vecs[1] = '{1'b1, 8'd120, 2'd3, 32'h6C6C6548, 4};
        vecs[2] = '{1'b1, 8'd36,  2'd0, 32'h00000048, 1};
        vecs[3] = '{1'b1, 8'd37,  2'd1, 32'h00006C65, 2};
        vecs[4] = '{1'b1, 8'd254, 2'd2, 32'h07B70101, 4};
        vecs[5] = '{1'b0, 8'd254, 2'd0, 32'h07B70101, 4};
        vecs[6] = '{1'b1, 8'd3,   2'd1, 32'h0000A100, 2};
        vecs[7] = '{1'b1, 8'd255, 2'd1, 32'h0000B701, 2};

        reset = 1'b1;
        i_req = 1'b0; i_addr = 8'd0;
        d_req = 1'b0; d_addr = 8'd0; d_size = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_gnt_valid", {28'd0, i_gnt, d_gnt, i_valid, d_valid}, 32'd0);
        check("rst_i_data", i_data, 32'd0);
        check("rst_d_data", d_data, 32'd0);

        // Tie from reset: I first, then strict alternation; each port runs twice.
        i_addr = 8'd0; d_addr = 8'd36; d_size = 2'd0;
        i_req = 1'b1; d_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_c = '{0, 6, 9, 15};
        exp_o = '{1'b0, 1'b1, 1'b0, 1'b1};
        i_done = 0;
        d_done = 0;
        for (int c = 0; c < 30 && (i_done < 2 || d_done < 2); c++) begin
            @(negedge clk);
            if (i_gnt) begin gcyc.push_back(c); gown.push_back(1'b0); end
            if (d_gnt) begin gcyc.push_back(c); gown.push_back(1'b1); end
            if (i_valid) begin
                i_done++;
                check("tie_i_data", i_data, 32'h000007B7);
                if (i_done == 2) i_req = 1'b0;
            end
            if (d_valid) begin
                d_done++;
                check("tie_d_data", d_data, 32'h00000048);
                if (d_done == 2) d_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("tie_ngrants", gcyc.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            act_c = (k < gcyc.size()) ? gcyc[k] : -1;
            act_o = (k < gown.size()) ? gown[k] : 1'bx;
            check($sformatf("tie_gnt%0d_cycle", k), act_c, exp_c[k]);
            check($sformatf("tie_gnt%0d_owner", k), {31'd0, act_o}, {31'd0, exp_o[k]});
        end

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].is_d, vecs[v].addr, vecs[v].size, vecs[v].exp, vecs[v].n,
                    $sformatf("vec%0d", v));
        end

        // Reset during the READ phase of a word fetch.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("abort_i_data", i_data, 32'd0);
        seen_v = i_valid | d_valid | i_gnt | d_gnt;
        repeat (6) begin
            @(negedge clk);
            seen_v = seen_v | i_valid | d_valid | i_gnt | d_gnt;
        end
        check("abort_no_valid", {31'd0, seen_v}, 32'd0);
        run_txn(1'b0, 8'd0, 2'd0, 32'h000007B7, 4, "refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
